// File: rtl/hamming_tx.sv
// hamming_tx
//   Encodes a 4-bit nibble as a Hamming(7,4) codeword, optionally flips one
//   code bit for error-injection testing, and sends the codeword on a UART-like
//   serial line: one start bit (0), seven code bits LSB first, one stop bit (1).
//   Each bit lasts CLKS_PER_BIT clock cycles.
//
// Ports
//   clk        system clock, rising-edge active
//   rst_n      synchronous active-low reset
//   data_i     nibble to encode (d1..d4 = data_i[0..3])
//   valid_i    data_i valid; a transfer happens when valid_i and ready_o are both 1
//   err_pos_i  code bit position 1..7 to invert, 0 = no injection
//   ready_o    idle and able to accept a nibble
//   code_o     last transmitted codeword, including any injected error
//   tx_o       registered serial output, idles high
//   done_o     one-cycle pulse in the first idle cycle after a frame
module hamming_tx #(
   parameter int CLKS_PER_BIT = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] data_i,
   input  logic       valid_i,
   input  logic [2:0] err_pos_i,
   output logic       ready_o,
   output logic [6:0] code_o,
   output logic       tx_o,
   output logic       done_o
);

   // The baud counter only needs to reach CLKS_PER_BIT-1; keep it at least
   // one bit wide so CLKS_PER_BIT=1 still elaborates.
   localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bitn, bitn_nxt;
   logic [6:0]    code_nxt;
   logic          tx_nxt;
   logic          done_nxt;
   logic          bit_end;

   // Hamming(7,4) with even parity; code index i holds Hamming position i+1,
   // so parity bits sit at the power-of-two positions 1, 2 and 4.
   function automatic logic [6:0] encode(input logic [3:0] d, input logic [2:0] err);
      logic [6:0] c;
      logic       p1, p2, p4;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p4 = d[1] ^ d[2] ^ d[3];
      c  = {d[3], d[2], d[1], p4, d[0], p2, p1};
      if (err != 3'd0)
         c[err - 3'd1] = ~c[err - 3'd1];
      return c;
   endfunction

   assign ready_o = (state == IDLE);
   assign bit_end = (cnt == CNT_LAST);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bitn_nxt  = bitn;
      code_nxt  = code_o;
      done_nxt  = 1'b0;

      // The line level is registered from the current state, so it trails the
      // state register by one cycle: tx_o drops on the edge after the transfer,
      // and the idle cycle after STOP shows up as exactly one high cycle when
      // the next transfer arrives with done_o.
      case (state)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = code_o[bitn];
         default: tx_nxt = 1'b1;
      endcase

      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            bitn_nxt = 3'd0;
            if (valid_i) begin
               state_nxt = START;
               code_nxt  = encode(data_i, err_pos_i);
            end
         end
         START: begin
            if (bit_end) begin
               cnt_nxt   = '0;
               state_nxt = DATA;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_nxt = '0;
               if (bitn == 3'd6) begin
                  bitn_nxt  = 3'd0;
                  state_nxt = STOP;
               end else begin
                  bitn_nxt = bitn + 3'd1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            bitn_nxt  = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         bitn   <= 3'd0;
         code_o <= 7'd0;
         tx_o   <= 1'b1;
         done_o <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         bitn   <= bitn_nxt;
         code_o <= code_nxt;
         tx_o   <= tx_nxt;
         done_o <= done_nxt;
      end
   end

endmodule
